// File: rtl/intersection_pkg.sv
// Shared phase encodings, default durations and lamp decode for intersection_controller.
package intersection_pkg;

  typedef enum logic [2:0] {
    AR_NS = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    AR_EW = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    WALK  = 3'd6
  } phase_t;

  localparam int DEF_GREEN_CYCLES  = 8;
  localparam int DEF_YELLOW_CYCLES = 3;
  localparam int DEF_ALLRED_CYCLES = 1;
  localparam int DEF_WALK_CYCLES   = 4;

  typedef struct packed {
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    logic ped_walk;
  } lamps_t;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Anything not a road's own green or yellow shows red on that road.
  function automatic lamps_t decode_lamps(input phase_t p);
    lamps_t l;
    l = '{ns_red: 1'b1, ns_yellow: 1'b0, ns_green: 1'b0,
          ew_red: 1'b1, ew_yellow: 1'b0, ew_green: 1'b0, ped_walk: 1'b0};
    case (p)
      NS_G: begin
        l.ns_red   = 1'b0;
        l.ns_green = 1'b1;
      end
      NS_Y: begin
        l.ns_red    = 1'b0;
        l.ns_yellow = 1'b1;
      end
      EW_G: begin
        l.ew_red   = 1'b0;
        l.ew_green = 1'b1;
      end
      EW_Y: begin
        l.ew_red    = 1'b0;
        l.ew_yellow = 1'b1;
      end
      WALK: l.ped_walk = 1'b1;
      default: l.ped_walk = 1'b0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intersection_controller_phase_timer.sv
// Loadable down-counter with hold and zero flag; times each intersection phase.
module phase_timer #(
  parameter int         W         = 3,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         hold,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Count down to zero and stop there until the next load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= RESET_VAL;
    end else if (load) begin
      count_r <= load_val;
    end else if (!hold && (count_r != '0)) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == '0);

endmodule

// File: rtl/intersection_controller.sv
// Two-road intersection phase sequencer with all-red clearance between greens.
// Optional pedestrian walk phase is enabled by defining PED_WALK_EN.
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int ALLRED_CYCLES = DEF_ALLRED_CYCLES,
  parameter int WALK_CYCLES   = DEF_WALK_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_req,
  input  logic       ew_req,
`ifdef PED_WALK_EN
  input  logic       ped_req,
  output logic       ped_walk,
`endif
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic [2:0] phase
);

`ifdef PED_WALK_EN
  localparam int MAX_DUR = max_int(max_int(GREEN_CYCLES, YELLOW_CYCLES),
                                   max_int(ALLRED_CYCLES, WALK_CYCLES));
`else
  localparam int MAX_DUR = max_int(max_int(GREEN_CYCLES, YELLOW_CYCLES), ALLRED_CYCLES);
`endif
  localparam int CW = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  phase_t        state_r;
  phase_t        next_s;
  lamps_t        lamps_r;
  logic          load_s;
  logic          hold_s;
  logic [CW-1:0] load_val_s;
  logic [CW-1:0] count_s;
  logic          zero_s;
  logic          end_ns_s;
  logic          end_ew_s;
  logic          ped_pend_s;

`ifdef PED_WALK_EN
  logic ped_pending_r;
  logic walk_from_ns_r;
  logic walk_entry_s;

  assign ped_pend_s   = ped_pending_r;
  assign walk_entry_s = (next_s == WALK) && (state_r != WALK);
`else
  assign ped_pend_s = 1'b0;
`endif

  assign end_ns_s = ew_req | ped_pend_s;
  assign end_ew_s = ns_req | ped_pend_s;

  // Next-phase selection; a green with no opposing demand rests with the timer held at zero.
  always_comb begin
    next_s = state_r;
    hold_s = 1'b0;
    case (state_r)
      AR_NS: if (zero_s) next_s = NS_G; else next_s = state_r;
      NS_G: begin
        if (zero_s && end_ns_s) begin
          next_s = NS_Y;
        end else begin
          next_s = state_r;
          hold_s = zero_s;
        end
      end
      NS_Y: begin
        if (zero_s) begin
          next_s = ped_pend_s ? WALK : AR_EW;
        end else begin
          next_s = state_r;
        end
      end
      AR_EW: if (zero_s) next_s = EW_G; else next_s = state_r;
      EW_G: begin
        if (zero_s && end_ew_s) begin
          next_s = EW_Y;
        end else begin
          next_s = state_r;
          hold_s = zero_s;
        end
      end
      EW_Y: begin
        if (zero_s) begin
          next_s = ped_pend_s ? WALK : AR_NS;
        end else begin
          next_s = state_r;
        end
      end
`ifdef PED_WALK_EN
      WALK: begin
        if (zero_s) begin
          next_s = walk_from_ns_r ? AR_EW : AR_NS;
        end else begin
          next_s = state_r;
        end
      end
`endif
      default: next_s = AR_NS;
    endcase
  end

  assign load_s = (next_s != state_r);

  // Duration of the phase being entered, loaded as duration minus one.
  always_comb begin
    load_val_s = CW'(ALLRED_CYCLES - 1);
    case (next_s)
      NS_G, EW_G: load_val_s = CW'(GREEN_CYCLES - 1);
      NS_Y, EW_Y: load_val_s = CW'(YELLOW_CYCLES - 1);
      WALK:       load_val_s = CW'(WALK_CYCLES - 1);
      default:    load_val_s = CW'(ALLRED_CYCLES - 1);
    endcase
  end

  phase_timer #(
    .W         (CW),
    .RESET_VAL (CW'(ALLRED_CYCLES - 1))
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .load_val (load_val_s),
    .hold     (hold_s),
    .count    (count_s),
    .zero     (zero_s)
  );

  // Lamps decode from the next phase so they switch on the same edge as the phase register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= AR_NS;
      lamps_r <= decode_lamps(AR_NS);
    end else begin
      state_r <= next_s;
      lamps_r <= decode_lamps(next_s);
    end
  end

`ifdef PED_WALK_EN
  // A new request in the walk-entry cycle survives so it is served by the next walk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped_pending_r  <= 1'b0;
      walk_from_ns_r <= 1'b0;
    end else begin
      ped_pending_r <= ped_req | (ped_pending_r & ~walk_entry_s);
      if (walk_entry_s) begin
        walk_from_ns_r <= (state_r == NS_Y);
      end else begin
        walk_from_ns_r <= walk_from_ns_r;
      end
    end
  end

  assign ped_walk = lamps_r.ped_walk;
`endif

  assign ns_red    = lamps_r.ns_red;
  assign ns_yellow = lamps_r.ns_yellow;
  assign ns_green  = lamps_r.ns_green;
  assign ew_red    = lamps_r.ew_red;
  assign ew_yellow = lamps_r.ew_yellow;
  assign ew_green  = lamps_r.ew_green;
  assign phase     = state_r;

endmodule
